// File: rtl/score_ram_arbiter.sv
// Score RAM owner: zeroes CLR_DEPTH slots after reset, then arbitrates the single-port RAM
// between port A (game controller) and port B (display). Define ARB_ROUND_ROBIN_EN for round-robin.
module score_ram_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int CLR_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_r_w,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              init_busy
);

  typedef enum logic [1:0] {CLEAR, IDLE, ACCESS, CAPTURE} state_t;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLR_DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                sel_b_q, sel_b_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_r_w_q, ram_r_w_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic                a_done_q, a_done_d, b_done_q, b_done_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic                init_busy_q, init_busy_d;
  logic                grant_a, grant_b;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_q=1 means B is preferred on a tie (A was granted most recently)
  logic rr_q, rr_d;

  always_comb begin
    grant_a = a_req && (!b_req || !rr_q);
    grant_b = b_req && (!a_req ||  rr_q);
  end

  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && (grant_a || grant_b)) rr_d = grant_a;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end
`else
  always_comb begin
    grant_a = a_req;
    grant_b = b_req && !a_req;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (cnt_q == CLR_LAST) state_d = IDLE;
      IDLE:    if (grant_a || grant_b) state_d = ACCESS;
      ACCESS:  state_d = we_q ? IDLE : CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cnt_d       = cnt_q;
    sel_b_d     = sel_b_q;
    we_d        = we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_r_w_d   = 1'b0;
    a_gnt_d     = 1'b0;
    b_gnt_d     = 1'b0;
    a_done_d    = 1'b0;
    b_done_d    = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    init_busy_d = init_busy_q;
    case (state_q)
      CLEAR: begin
        ram_addr_d  = cnt_q;
        ram_wdata_d = '0;
        ram_r_w_d   = 1'b1;
        cnt_d       = cnt_q + 1'b1;
      end
      IDLE: begin
        init_busy_d = 1'b0;
        if (grant_a) begin
          ram_addr_d  = a_addr;
          ram_wdata_d = a_wdata;
          ram_r_w_d   = a_we;
          a_gnt_d     = 1'b1;
          sel_b_d     = 1'b0;
          we_d        = a_we;
        end else if (grant_b) begin
          ram_addr_d  = b_addr;
          ram_wdata_d = b_wdata;
          ram_r_w_d   = b_we;
          b_gnt_d     = 1'b1;
          sel_b_d     = 1'b1;
          we_d        = b_we;
        end
      end
      ACCESS: begin
        if (we_q) begin
          a_done_d = !sel_b_q;
          b_done_d =  sel_b_q;
        end
      end
      CAPTURE: begin
        // RAM data for the address presented at the grant edge is valid now
        if (sel_b_q) begin
          b_rdata_d = ram_rdata;
          b_done_d  = 1'b1;
        end else begin
          a_rdata_d = ram_rdata;
          a_done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      sel_b_q     <= 1'b0;
      we_q        <= 1'b0;
      ram_addr_q  <= '0;
      ram_r_w_q   <= 1'b0;
      ram_wdata_q <= '0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      init_busy_q <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      sel_b_q     <= sel_b_d;
      we_q        <= we_d;
      ram_addr_q  <= ram_addr_d;
      ram_r_w_q   <= ram_r_w_d;
      ram_wdata_q <= ram_wdata_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_done_q    <= a_done_d;
      b_done_q    <= b_done_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      init_busy_q <= init_busy_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_r_w   = ram_r_w_q;
  assign ram_wdata = ram_wdata_q;
  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign a_done    = a_done_q;
  assign b_done    = b_done_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign init_busy = init_busy_q;

endmodule

// File: tb/tb_score_ram_arbiter.sv
// Bench for score_ram_arbiter: directed handshake sequences then randomized traffic,
// checked every cycle against a transaction-schedule model of the arbiter.
module tb_score_ram_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int CLR = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, a_done, b_gnt, b_done, ram_r_w, init_busy;
  logic [DW-1:0] a_rdata, b_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  score_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLR_DEPTH(CLR)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_r_w(ram_r_w), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .init_busy(init_busy)
  );

  // Single-port RAM with one cycle read latency
  logic [DW-1:0] ram_mem [256];
  always @(posedge clk) begin
    ram_rdata <= ram_mem[ram_addr];
    if (ram_r_w) ram_mem[ram_addr] = ram_wdata;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each accepted request becomes a scheduled grant/done event
  logic [DW-1:0] mm [256];
  bit            mvalid = 0, clearing = 0, dpend = 0, dport_b = 0, dwe = 0, last_b = 1;
  int            cyc = 0, clr_idx = 0, next_sample = 0, dcyc = 0;
  logic [DW-1:0] ddata;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_ard, e_brd;
  logic          e_rw, e_agnt, e_bgnt, e_adone, e_bdone, e_busy;

  always @(posedge clk) begin
    bit            use_b, we;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    cyc++;
    if (reset) begin
      mvalid = 1; clearing = 1; clr_idx = 0; dpend = 0; last_b = 1;
      e_addr = '0; e_wdata = '0; e_rw = 0; e_agnt = 0; e_bgnt = 0;
      e_adone = 0; e_bdone = 0; e_ard = '0; e_brd = '0; e_busy = 1;
    end else if (mvalid) begin
      e_agnt = 0; e_bgnt = 0; e_adone = 0; e_bdone = 0; e_rw = 0;
      if (clearing) begin
        e_addr = AW'(clr_idx); e_wdata = '0; e_rw = 1;
        mm[clr_idx] = '0;
        clr_idx++;
        if (clr_idx == CLR) begin
          clearing = 0;
          next_sample = cyc + 1;
        end
      end else begin
        if (dpend && cyc == dcyc) begin
          dpend = 0;
          if (dport_b) begin e_bdone = 1; if (!dwe) e_brd = ddata; end
          else         begin e_adone = 1; if (!dwe) e_ard = ddata; end
        end
        if (cyc >= next_sample) begin
          e_busy = 0;
          if (a_req || b_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            use_b = (a_req && b_req) ? !last_b : b_req;
`else
            use_b = !a_req;
`endif
            ad = use_b ? b_addr : a_addr;
            wd = use_b ? b_wdata : a_wdata;
            we = use_b ? b_we : a_we;
            e_addr = ad; e_wdata = wd; e_rw = we;
            if (use_b) e_bgnt = 1; else e_agnt = 1;
            ddata = mm[ad];
            if (we) mm[ad] = wd;
            dpend = 1; dport_b = use_b; dwe = we;
            dcyc = cyc + (we ? 1 : 2);
            next_sample = cyc + (we ? 2 : 3);
            last_b = use_b;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (mvalid) begin
      check("m_ram_addr", ram_addr, e_addr);
      check("m_ram_r_w", ram_r_w, e_rw);
      check("m_ram_wdata", ram_wdata, e_wdata);
      check("m_a_gnt", a_gnt, e_agnt);
      check("m_b_gnt", b_gnt, e_bgnt);
      check("m_a_done", a_done, e_adone);
      check("m_b_done", b_done, e_bdone);
      check("m_a_rdata", a_rdata, e_ard);
      check("m_b_rdata", b_rdata, e_brd);
      check("m_init_busy", init_busy, e_busy);
    end
  end

  task automatic new_req_a();
    a_req = 1; a_we = 1'($urandom_range(0, 1));
    a_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
    a_wdata = DW'($urandom);
  endtask

  task automatic new_req_b();
    b_req = 1; b_we = ($urandom_range(0, 3) == 0);
    b_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
    b_wdata = DW'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom) | 8'h80;
      ram_mem[i] = v;
      mm[i] = v;
    end
    repeat (2) @(negedge clk);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_r_w", ram_r_w, 0);
    check("rst_init_busy", init_busy, 1);
    check("rst_a_gnt", a_gnt, 0);

    // Clear sequence with a read request held throughout
    reset = 0; a_req = 1; a_we = 0; a_addr = 1; a_wdata = 8'h77;
    for (int i = 0; i < CLR; i++) begin
      @(negedge clk);
      check("clr_addr", ram_addr, i);
      check("clr_r_w", ram_r_w, 1);
      check("clr_wdata", ram_wdata, 0);
      check("clr_no_gnt", a_gnt, 0);
      check("clr_busy", init_busy, 1);
    end
    @(negedge clk);
    check("idle_busy", init_busy, 0);
    check("idle_r_w", ram_r_w, 0);
    check("first_a_gnt", a_gnt, 1);
    check("first_addr", ram_addr, 1);
    a_req = 0;
    @(negedge clk);
    check("rd_no_early_done", a_done, 0);
    @(negedge clk);
    check("rd_a_done", a_done, 1);
    check("rd_a_rdata_cleared", a_rdata, 0);

    // Port A write of 0x05 to slot 2
    a_req = 1; a_we = 1; a_addr = 2; a_wdata = 8'h05;
    @(negedge clk);
    check("wr_a_gnt", a_gnt, 1);
    check("wr_addr", ram_addr, 2);
    check("wr_r_w", ram_r_w, 1);
    check("wr_wdata", ram_wdata, 8'h05);
    check("wr_b_gnt", b_gnt, 0);
    a_req = 0;
    @(negedge clk);
    check("wr_a_done", a_done, 1);
    check("wr_b_done", b_done, 0);
    check("wr_r_w_off", ram_r_w, 0);

    // Port B readback of slot 2
    b_req = 1; b_we = 0; b_addr = 2; b_wdata = 8'h00;
    @(negedge clk);
    check("rb_b_gnt", b_gnt, 1);
    check("rb_r_w", ram_r_w, 0);
    b_req = 0;
    @(negedge clk);
    check("rb_gap", b_done, 0);
    @(negedge clk);
    check("rb_b_done", b_done, 1);
    check("rb_b_rdata", b_rdata, 8'h05);

    // Both held continuously
    a_req = 1; a_we = 1; a_addr = 3; a_wdata = 8'h11;
    b_req = 1; b_we = 1; b_addr = 4; b_wdata = 8'h22;
    for (int k = 0; k < 4; k++) begin
      bit exp_b;
`ifdef ARB_ROUND_ROBIN_EN
      exp_b = (k % 2) == 1;
`else
      exp_b = 0;
`endif
      @(negedge clk);
      check("sim_a_gnt", a_gnt, !exp_b);
      check("sim_b_gnt", b_gnt, exp_b);
      @(negedge clk);
    end
    a_req = 0;
    @(negedge clk);
    check("sim_b_after_a", b_gnt, 1);
    b_req = 0;
    @(negedge clk);
    check("sim_b_done", b_done, 1);

    // B held while A pulses once
    b_req = 1; b_we = 0; b_addr = 3; b_wdata = 8'h00;
    a_req = 1; a_we = 1; a_addr = 5; a_wdata = 8'h33;
    @(negedge clk);
    check("stv_a_gnt", a_gnt, 1);
    check("stv_b_wait", b_gnt, 0);
    a_req = 0;
    @(negedge clk);
    check("stv_a_done", a_done, 1);
    @(negedge clk);
    check("stv_b_gnt", b_gnt, 1);
    check("stv_b_addr", ram_addr, 3);
    b_req = 0;
    @(negedge clk);
    @(negedge clk);
    check("stv_b_done", b_done, 1);
    check("stv_b_rdata", b_rdata, 8'h11);

    // Reset while a B read sits in CAPTURE
    b_req = 1; b_we = 0; b_addr = 2;
    @(negedge clk);
    check("mid_b_gnt", b_gnt, 1);
    b_req = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("mid_no_done", b_done, 0);
    check("mid_rdata_rst", b_rdata, 0);
    check("mid_busy", init_busy, 1);
    check("mid_r_w", ram_r_w, 0);
    reset = 0;
    @(negedge clk);
    check("mid_clr_addr0", ram_addr, 0);
    check("mid_clr_r_w", ram_r_w, 1);

    // Randomized traffic with occasional resets
    repeat (4000) begin
      @(negedge clk);
      if (reset) reset = 0;
      else if ($urandom_range(0, 399) == 0) reset = 1;
      if (a_req && a_gnt) begin
        if ($urandom_range(0, 3) == 0) new_req_a(); else a_req = 0;
      end else if (!a_req && $urandom_range(0, 2) == 0) new_req_a();
      if (b_req && b_gnt) begin
        if ($urandom_range(0, 3) == 0) new_req_b(); else b_req = 0;
      end else if (!b_req && $urandom_range(0, 2) == 0) new_req_b();
    end
    a_req = 0; b_req = 0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
